// File: rtl/shift_pkg.sv
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and defaults for the shift/latch serial link.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } shift_state_t;

    localparam int SHIFT_WIDTH_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/shift_hold_reg.sv
// ============================================================================
//  Module      : shift_hold_reg
//  Description : One-entry valid/ready holding register, drained by the FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_hold_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic             shift_clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             drain,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_valid
);

    // Accept only while empty, so a full register is never overwritten.
    always_ff @(posedge shift_clk) begin
        if (!nreset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (in_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    assign in_ready = ~hold_valid;

endmodule

`default_nettype wire

// File: rtl/shift_out16_tx.sv
// ============================================================================
//  Module      : shift_out16_tx
//  Description : MSB-first serial transmitter for the data/clock/latch link.
//                Optional auto-refresh of the last word: SHIFT_OUT16_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_out16_tx
    import shift_pkg::*;
#(
    parameter int WIDTH        = SHIFT_WIDTH_DEFAULT,
    parameter int LATCH_CYCLES = 1
) (
    input  logic             shift_clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             sout_data,
    output logic             sout_clk,
    output logic             sout_latch
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    shift_state_t     state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             shift_en;

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             drain;
    logic             frame_end;
    logic             load_now;
    logic [WIDTH-1:0] load_word;

`ifdef SHIFT_OUT16_REPEAT_EN
    logic [WIDTH-1:0] last_word;
    logic             sent;
`endif

    shift_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .shift_clk  (shift_clk),
        .nreset     (nreset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .drain      (drain),
        .hold_data  (hold_data),
        .hold_valid (hold_valid)
    );

    // A waiting word always wins over a refresh at the frame boundary.
    always_comb begin
        frame_end = (state == LATCH) && (lat_cnt == '0);
        drain     = hold_valid && ((state == IDLE) || frame_end);
        load_now  = drain;
        load_word = hold_data;
`ifdef SHIFT_OUT16_REPEAT_EN
        if (!hold_valid && frame_end && sent) begin
            load_now  = 1'b1;
            load_word = last_word;
        end
`endif
    end

    always_ff @(posedge shift_clk) begin
        if (!nreset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            lat_cnt    <= '0;
            shift_en   <= 1'b0;
            sout_data  <= 1'b0;
            sout_latch <= 1'b0;
            frame_done <= 1'b0;
`ifdef SHIFT_OUT16_REPEAT_EN
            last_word  <= '0;
            sent       <= 1'b0;
`endif
        end else if (load_now) begin
            // MSB goes straight to the pin; shreg holds the remaining bits.
            state      <= SHIFT;
            shreg      <= {load_word[WIDTH-2:0], 1'b0};
            cnt        <= CNT_LAST;
            shift_en   <= 1'b1;
            sout_data  <= load_word[WIDTH-1];
            sout_latch <= 1'b0;
            frame_done <= 1'b0;
`ifdef SHIFT_OUT16_REPEAT_EN
            last_word  <= load_word;
            sent       <= 1'b1;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == '0) begin
                        state      <= LATCH;
                        shift_en   <= 1'b0;
                        sout_data  <= 1'b0;
                        sout_latch <= 1'b1;
                        lat_cnt    <= LAT_LAST;
                        frame_done <= (LAT_LAST == '0);
                    end else begin
                        shreg     <= {shreg[WIDTH-2:0], 1'b0};
                        sout_data <= shreg[WIDTH-1];
                        cnt       <= cnt - 1'b1;
                    end
                end
                LATCH: begin
                    if (lat_cnt == '0) begin
                        state      <= IDLE;
                        sout_latch <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        lat_cnt    <= lat_cnt - 1'b1;
                        frame_done <= (lat_cnt == LAT_W'(1));
                    end
                end
                default: begin
                    state      <= IDLE;
                    shift_en   <= 1'b0;
                    sout_data  <= 1'b0;
                    sout_latch <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    // shift_en only moves while shift_clk is high, so the gated clock cannot glitch.
    assign sout_clk = ~shift_clk & shift_en;
    assign busy     = (state != IDLE) | hold_valid;

endmodule

`default_nettype wire

// File: tb/tb_shift_out16_tx.sv
// ============================================================================
//  Module      : tb_shift_out16_tx
//  Description : Directed bench for shift_out16_tx with a ShiftIn16-style receiver model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift_out16_tx;

    logic        shift_clk = 1'b0;
    logic        nreset    = 1'b0;
    logic [15:0] in_data1  = '0;
    logic [15:0] in_data2  = '0;
    logic        in_valid1 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        in_ready1, busy1, frame_done1, sout_data1, sout_clk1, sout_latch1;
    logic        in_ready2, busy2, frame_done2, sout_data2, sout_clk2, sout_latch2;

    always #5 shift_clk = ~shift_clk;

    shift_out16_tx dut1 (
        .shift_clk  (shift_clk),
        .nreset     (nreset),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .busy       (busy1),
        .frame_done (frame_done1),
        .sout_data  (sout_data1),
        .sout_clk   (sout_clk1),
        .sout_latch (sout_latch1)
    );

    shift_out16_tx #(
        .WIDTH        (16),
        .LATCH_CYCLES (3)
    ) dut2 (
        .shift_clk  (shift_clk),
        .nreset     (nreset),
        .in_data    (in_data2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .busy       (busy2),
        .frame_done (frame_done2),
        .sout_data  (sout_data2),
        .sout_clk   (sout_clk2),
        .sout_latch (sout_latch2)
    );

    // Receiver models: shift on sout_clk rise, commit on sout_latch rise.
    logic [15:0] rx_sr1 = '0, rx_word1 = '0, rx_prev1 = '0;
    logic [15:0] rx_sr2 = '0, rx_word2 = '0, rx_prev2 = '0;
    int          rises1 = 0;

    always @(posedge sout_clk1) begin
        rx_sr1 <= {rx_sr1[14:0], sout_data1};
        rises1 <= rises1 + 1;
    end
    always @(posedge sout_latch1) begin
        rx_prev1 <= rx_word1;
        rx_word1 <= rx_sr1;
    end
    always @(posedge sout_clk2) rx_sr2 <= {rx_sr2[14:0], sout_data2};
    always @(posedge sout_latch2) begin
        rx_prev2 <= rx_word2;
        rx_word2 <= rx_sr2;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge shift_clk);
        #1;
    endtask

    task automatic send(input int which, input logic [15:0] w);
        int t = 0;
        while (((which == 1) ? !in_ready1 : !in_ready2) && t < 200) begin
            tick();
            t++;
        end
        check("send_ready_wait", 32'(t < 200), 32'd1);
        if (which == 1) begin in_data1 = w; in_valid1 = 1'b1; end
        else            begin in_data2 = w; in_valid2 = 1'b1; end
        tick();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_data1  = 16'h0BAD;
        in_data2  = 16'h0BAD;
    endtask

    task automatic wait_word(input int which, input logic [15:0] w, input string tag);
        int t = 0;
        while (((which == 1) ? rx_word1 : rx_word2) !== w && t < 300) begin
            tick();
            t++;
        end
        check(tag, (which == 1) ? 32'(rx_word1) : 32'(rx_word2), 32'(w));
    endtask

    logic [15:0] bits;
    logic        latch_seen;
    int          r, t;
    int          rise_t [2];
    int          nr, run0, fd_pos, fd_cnt;
    logic        prev;

    initial begin
        // 1: reset held two cycles with a word offered
        nreset    = 1'b0;
        in_valid1 = 1'b1;
        in_data1  = 16'hDEAD;
        tick();
        r = rises1;
        tick();
        tick();
        check("rst_sout_data",  32'(sout_data1),  32'd0);
        check("rst_sout_latch", 32'(sout_latch1), 32'd0);
        check("rst_frame_done", 32'(frame_done1), 32'd0);
        check("rst_busy",       32'(busy1),       32'd0);
        check("rst_no_sclk",    32'(rises1 - r),  32'd0);
        in_valid1 = 1'b0;
        nreset    = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready1), 32'd1);
        check("rst_idle",     32'(busy1),     32'd0);

        // 2: single frame 0xA5C3, exact latency and bit order
        r = rises1;
        send(1, 16'hA5C3);
        check("t2_hold_full", 32'(in_ready1), 32'd0);
        bits       = '0;
        latch_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            bits       = {bits[14:0], sout_data1};
            latch_seen = latch_seen | sout_latch1;
        end
        check("t2_bits",        32'(bits),       32'hA5C3);
        check("t2_no_early_latch", 32'(latch_seen), 32'd0);
        tick();
        check("t2_latch",      32'(sout_latch1), 32'd1);
        check("t2_frame_done", 32'(frame_done1), 32'd1);
        check("t2_rises",      32'(rises1 - r),  32'd16);
        tick();
        check("t2_latch_len",  32'(sout_latch1), 32'd0);
        check("t2_rx_word",    32'(rx_word1),    32'hA5C3);
`ifndef SHIFT_OUT16_REPEAT_EN
        check("t2_idle", 32'(busy1), 32'd0);
`endif

        // 3: back-to-back frames, no idle gap
        send(1, 16'h0001);
        check("t3_ready_low", 32'(in_ready1), 32'd0);
        send(1, 16'hFFFF);
        wait_word(1, 16'h0001, "t3_rx_first");
        tick();
        check("t3_no_gap_latch", 32'(sout_latch1), 32'd0);
        check("t3_no_gap_sclk",  32'(sout_clk1),   32'd1);
        wait_word(1, 16'hFFFF, "t3_rx_second");
        check("t3_rx_prev", 32'(rx_prev1), 32'h0001);

        // 4: reset after seven bits of 0x1234
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
        r = rises1;
        send(1, 16'h1234);
        t = 0;
        while (rises1 < r + 7 && t < 50) begin
            tick();
            t++;
        end
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("t4_bits_sent", 32'(rises1 - r), 32'd7);
        check("t4_in_ready",  32'(in_ready1),  32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("t4_sclk_stopped", 32'(rises1 - r),  32'd7);
        check("t4_no_latch",     32'(sout_latch1), 32'd0);
        check("t4_busy",         32'(busy1),       32'd0);
        check("t4_rx_kept",      32'(rx_word1),    32'hFFFF);
        send(1, 16'h00FF);
        wait_word(1, 16'h00FF, "t4_fresh_frame");

        // 5: LATCH_CYCLES=3 latch width and frame period
        send(2, 16'h8000);
        send(2, 16'h0001);
        nr = 0; run0 = 0; fd_pos = 0; fd_cnt = 0; prev = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (sout_latch2 && !prev) begin
                if (nr < 2) rise_t[nr] = i;
                nr++;
            end
            if (nr == 1 && sout_latch2) run0++;
            if (nr == 1 && frame_done2) begin
                fd_cnt++;
                fd_pos = run0;
            end
            prev = sout_latch2;
        end
        check("t5_two_frames", 32'(nr >= 2), 32'd1);
        check("t5_latch_len",  32'(run0),    32'd3);
        check("t5_fd_pos",     32'(fd_pos),  32'd3);
        check("t5_fd_count",   32'(fd_cnt),  32'd1);
        check("t5_period",     32'(rise_t[1] - rise_t[0]), 32'd19);
        wait_word(2, 16'h0001, "t5_rx_second");
        check("t5_rx_first",   32'(rx_prev2), 32'h8000);

        // 6: behaviour after the last frame
`ifdef SHIFT_OUT16_REPEAT_EN
        nr = 0; prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (sout_latch1 && !prev) begin
                if (nr < 2) rise_t[nr] = i;
                nr++;
            end
            prev = sout_latch1;
        end
        check("t6_repeat_seen",   32'(nr >= 2),  32'd1);
        check("t6_repeat_period", 32'(rise_t[1] - rise_t[0]), 32'd17);
        check("t6_repeat_word",   32'(rx_word1), 32'h00FF);
        send(1, 16'hBEEF);
        wait_word(1, 16'hBEEF, "t6_switch");
        r = rises1;
        for (int i = 0; i < 40; i++) tick();
        check("t6_still_refresh", 32'(rises1 - r >= 16), 32'd1);
        check("t6_refresh_word",  32'(rx_prev1),          32'hBEEF);
`else
        r = rises1;
        for (int i = 0; i < 40; i++) tick();
        check("t6_idle_sclk", 32'(rises1 - r), 32'd0);
        check("t6_idle_busy", 32'(busy1),      32'd0);
        check("t6_rx_word",   32'(rx_word1),   32'h00FF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
